// File: rtl/tpu_operand_feeder.sv
// tpu_operand_feeder: FIFO-buffered sequencer that frames minifloat operand pairs into MAC dot products.
// Define TPU_FEEDER_STATS_EN to enable the per-product issued-pair counter on stat_pairs.
module tpu_operand_feeder #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic        in_last,
  output logic [7:0]  mac_a,
  output logic [7:0]  mac_b,
  output logic        mac_valid,
  output logic        mac_clr,
  output logic        mac_out_HL,
  input  logic [15:0] mac_out,
  input  logic        mac_error,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_error,
  output logic [15:0] stat_pairs
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(MAC_LAT + 2);
  localparam logic [CW-1:0] LAT_C = CW'(MAC_LAT);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_STREAM  = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_READ_LO = 3'd4;
  localparam logic [2:0] ST_READ_HI = 3'd5;
  localparam logic [2:0] ST_HOLD    = 3'd6;

  logic [16:0]   mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          empty, full, push, pop;
  logic [16:0]   head;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] drain_q, drain_d;
  logic          err_q, err_d;
  logic [7:0]    mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic          mac_valid_q, mac_valid_d, mac_clr_q, mac_clr_d;
  logic [31:0]   res_data_q, res_data_d;
  logic          res_error_q, res_error_d;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = ~reset & ~full;
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == ST_STREAM) & ~empty;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    err_d       = err_q;
    mac_a_d     = '0;
    mac_b_d     = '0;
    mac_valid_d = 1'b0;
    mac_clr_d   = 1'b0;
    res_data_d  = res_data_q;
    res_error_d = res_error_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        mac_clr_d = 1'b1;
        err_d     = 1'b0;
        state_d   = ST_STREAM;
      end
      ST_STREAM: begin
        err_d = err_q | mac_error;
        if (!empty) begin
          mac_a_d     = head[15:8];
          mac_b_d     = head[7:0];
          mac_valid_d = 1'b1;
          if (head[16]) begin
            drain_d = LAT_C;
            state_d = (MAC_LAT == 0) ? ST_READ_LO : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        err_d = err_q | mac_error;
        if (drain_q != '0) drain_d = drain_q - 1'b1;
        if (drain_q <= CW'(1)) state_d = ST_READ_LO;
      end
      ST_READ_LO: begin
        res_data_d[15:0] = mac_out;
        state_d          = ST_READ_HI;
      end
      ST_READ_HI: begin
        res_data_d[31:16] = mac_out;
        state_d           = ST_HOLD;
      end
      ST_HOLD: begin
        // Skip IDLE when work is already queued so CLEAR follows the handshake directly
        if (res_ready) state_d = empty ? ST_IDLE : ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_d == ST_READ_LO) && (state_q != ST_READ_LO)) res_error_d = err_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      err_q       <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_valid_q <= 1'b0;
      mac_clr_q   <= 1'b0;
      res_data_q  <= '0;
      res_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      err_q       <= err_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_valid_q <= mac_valid_d;
      mac_clr_q   <= mac_clr_d;
      res_data_q  <= res_data_d;
      res_error_q <= res_error_d;
    end
  end

  assign mac_a      = mac_a_q;
  assign mac_b      = mac_b_q;
  assign mac_valid  = mac_valid_q;
  assign mac_clr    = mac_clr_q;
  assign mac_out_HL = (state_q == ST_READ_HI);
  assign res_valid  = (state_q == ST_HOLD);
  assign res_data   = res_data_q;
  assign res_error  = res_error_q;

`ifdef TPU_FEEDER_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      stat_q <= '0;
    end else if (mac_valid_q && (stat_q != '1)) begin
      stat_q <= stat_q + 1'b1;
    end
  end

  assign stat_pairs = stat_q;
`else
  assign stat_pairs = '0;
`endif

endmodule

// File: tb/tb_tpu_operand_feeder.sv
// Self-checking bench for tpu_operand_feeder: table-driven products plus hand-written corner sequences,
// with a behavioural accumulator standing in for the MAC (product = a*b as unsigned integers).
module tb_tpu_operand_feeder;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned MAC_LAT = 1;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b;
  logic        in_last;
  logic [7:0]  mac_a, mac_b;
  logic        mac_valid, mac_clr, mac_out_HL;
  logic [15:0] mac_out;
  logic        mac_error;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_error;
  logic [15:0] stat_pairs;

  tpu_operand_feeder #(.DEPTH(DEPTH), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_a(mac_a), .mac_b(mac_b), .mac_valid(mac_valid), .mac_clr(mac_clr),
    .mac_out_HL(mac_out_HL), .mac_out(mac_out), .mac_error(mac_error),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
    .stat_pairs(stat_pairs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC model: one-cycle latency accumulator of a*b
  logic [31:0] acc_q;
  always @(posedge clk) begin
    if (reset || mac_clr) acc_q <= '0;
    else                  acc_q <= acc_q + 32'(mac_a) * 32'(mac_b);
  end
  assign mac_out = mac_out_HL ? acc_q[31:16] : acc_q[15:0];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        last;
    int unsigned gap;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } res_t;

  vec_t        vecs[17];
  res_t        exp_res_q[$];
  logic [15:0] exp_pair_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          auto_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: pairs and results pop as the DUT produces them
  always @(negedge clk) begin
    logic [15:0] p;
    res_t        r;
    if (!reset) begin
      if (mac_valid) begin
        if (exp_pair_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pair: got %h%h expected none", mac_a, mac_b);
        end else begin
          p = exp_pair_q.pop_front();
          check("mac_pair", {16'h0, mac_a, mac_b}, {16'h0, p});
        end
      end else begin
        check("bubble_zero", {16'h0, mac_a, mac_b}, 32'h0);
      end
      if (res_valid && res_ready) begin
        if (exp_res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got %h expected none", res_data);
        end else begin
          r = exp_res_q.pop_front();
          check("res_data", res_data, r.data);
          check("res_error", {31'h0, res_error}, {31'h0, r.err});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (auto_ready) res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called 1ns after a rising edge; returns 1ns after the next one
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic last,
                      input logic [31:0] exp, input logic err, output logic acc);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    acc      = v && in_ready;
    @(posedge clk);
    if (acc) begin
      exp_pair_q.push_back({a, b});
      if (last) exp_res_q.push_back('{data: exp, err: err});
    end
    #1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    logic d;
    repeat (n) step(1'b0, 8'h0, 8'h0, 1'b0, 32'h0, 1'b0, d);
  endtask

  task automatic push_until(input logic [7:0] a, input logic [7:0] b, input logic last,
                            input logic [31:0] exp, input logic err);
    logic acc;
    acc = 1'b0;
    for (int unsigned i = 0; i < 100 && !acc; i++) step(1'b1, a, b, last, exp, err, acc);
    check("push_accepted", {31'h0, acc}, 32'h1);
  endtask

  task automatic wait_results(input int unsigned bound);
    for (int unsigned i = 0; i < bound && exp_res_q.size() != 0; i++) idle(1);
    check("results_drained", exp_res_q.size(), 32'h0);
    idle(3);
  endtask

  task automatic wait_mac_valid(input int unsigned bound);
    for (int unsigned i = 0; i < bound && !mac_valid; i++) idle(1);
    check("mac_valid_seen", {31'h0, mac_valid}, 32'h1);
  endtask

  initial begin
    logic acc;
    int   bubbles, clrs, quiet;
    bit   seen2, seen3;

    vecs[0]  = '{8'h08, 8'h08, 1'b1, 0, 32'h0000_0040};
    vecs[1]  = '{8'hFF, 8'hFF, 1'b0, 0, 32'h0};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b0, 0, 32'h0};
    vecs[3]  = '{8'h10, 8'h10, 1'b1, 0, 32'h0001_FD02};
    vecs[4]  = '{8'h02, 8'h03, 1'b0, 2, 32'h0};
    vecs[5]  = '{8'h04, 8'h05, 1'b0, 0, 32'h0};
    vecs[6]  = '{8'h80, 8'h80, 1'b0, 3, 32'h0};
    vecs[7]  = '{8'h01, 8'h01, 1'b1, 0, 32'h0000_401B};
    vecs[8]  = '{8'h7F, 8'h02, 1'b0, 0, 32'h0};
    vecs[9]  = '{8'hC0, 8'hC0, 1'b0, 1, 32'h0};
    vecs[10] = '{8'hFF, 8'h01, 1'b1, 0, 32'h0000_91FD};
    for (int unsigned i = 11; i < 17; i++) vecs[i] = '{8'hFF, 8'hFF, (i == 16), 0, 32'h0005_F406};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    mac_error = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_mac", {13'h0, mac_a, mac_b, mac_valid, mac_clr, mac_out_HL}, 32'h0);
    check("rst_res_flags", {30'h0, res_valid, res_error}, 32'h0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_stat", {16'h0, stat_pairs}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", {31'h0, in_ready}, 32'h1);

    // Single-pair product with exact cycle positions
    step(1'b1, 8'h08, 8'h08, 1'b1, 32'h0000_0040, 1'b0, acc);
    check("t1_accept", {31'h0, acc}, 32'h1);
    idle(1);
    check("t1_clr_k1", {31'h0, mac_clr}, 32'h0);
    idle(1);
    check("t1_clr_k2", {30'h0, mac_clr, mac_valid}, 32'h2);
    idle(1);
    check("t1_pair_k3", {15'h0, mac_valid, mac_clr, mac_a, mac_b}, {15'h0, 1'b1, 1'b0, 16'h0808});
    idle(1);
    check("t1_valid_k4", {31'h0, mac_valid}, 32'h0);
    idle(1);
    check("t1_res_valid_k5", {31'h0, res_valid}, 32'h0);
    idle(1);
    check("t1_res_valid_k6", {31'h0, res_valid}, 32'h1);
    check("t1_res_data", res_data, 32'h0000_0040);
`ifdef TPU_FEEDER_STATS_EN
    check("t1_stat", {16'h0, stat_pairs}, 32'h1);
`else
    check("t1_stat", {16'h0, stat_pairs}, 32'h0);
`endif
    auto_ready = 1'b1;
    wait_results(50);

    // Table-driven products with random consumer back-pressure
    for (int unsigned i = 1; i < 17; i++) begin
      idle(vecs[i].gap);
      push_until(vecs[i].a, vecs[i].b, vecs[i].last, vecs[i].exp, 1'b0);
    end
    wait_results(1000);

    // Input gap of 3 cycles while streaming caught up -> exactly 3 bubbles
    push_until(8'h01, 8'h02, 1'b0, 32'h0, 1'b0);
    wait_mac_valid(20);
    step(1'b1, 8'h03, 8'h04, 1'b0, 32'h0, 1'b0, acc);
    check("gap_p2_accept", {31'h0, acc}, 32'h1);
    bubbles = 0;
    clrs    = 0;
    seen2   = 1'b0;
    seen3   = 1'b0;
    for (int unsigned c = 0; c < 10; c++) begin
      if (c == 3) begin
        step(1'b1, 8'h05, 8'h06, 1'b1, 32'h0000_002C, 1'b0, acc);
        check("gap_p3_accept", {31'h0, acc}, 32'h1);
      end else begin
        idle(1);
      end
      if (mac_clr) clrs++;
      if (seen2 && !seen3 && !mac_valid) bubbles++;
      if (mac_valid && mac_a == 8'h03) seen2 = 1'b1;
      if (mac_valid && mac_a == 8'h05) seen3 = 1'b1;
    end
    check("gap_bubbles", bubbles, 32'd3);
    check("gap_no_clr", clrs, 32'd0);
    check("gap_p3_seen", {31'h0, seen3}, 32'h1);
    wait_results(100);

    // Single-cycle mac_error while streaming; next product must report clean
    push_until(8'h10, 8'h01, 1'b0, 32'h0, 1'b0);
    push_until(8'h10, 8'h02, 1'b0, 32'h0, 1'b0);
    push_until(8'h10, 8'h03, 1'b1, 32'h0000_0060, 1'b1);
    wait_mac_valid(20);
    mac_error = 1'b1;
    idle(1);
    mac_error = 1'b0;
    wait_results(100);
    push_until(8'h20, 8'h02, 1'b1, 32'h0000_0040, 1'b0);
    wait_results(100);

    // HOLD stall with FIFO filling, then CLEAR right after the handshake
    auto_ready = 1'b0;
    res_ready  = 1'b0;
    idle(1);
    push_until(8'h03, 8'h03, 1'b1, 32'h0000_0009, 1'b0);
    for (int unsigned i = 0; i < 30 && !res_valid; i++) idle(1);
    check("hold_res_valid", {31'h0, res_valid}, 32'h1);
    for (int unsigned i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 8'h01, 1'b0, 32'h0, 1'b0, acc);
      check("fill_accept", {31'h0, acc}, 32'h1);
    end
    check("full_in_ready", {31'h0, in_ready}, 32'h0);
    for (int unsigned i = 0; i < 5; i++) begin
      step(1'b1, 8'h09, 8'h01, 1'b1, 32'h0000_002D, 1'b0, acc);
      check("full_reject", {31'h0, acc}, 32'h0);
      check("hold_stable", res_data, 32'h0000_0009);
      check("hold_valid", {31'h0, res_valid}, 32'h1);
    end
    res_ready = 1'b1;
    step(1'b1, 8'h09, 8'h01, 1'b1, 32'h0000_002D, 1'b0, acc);
    res_ready = 1'b0;
    check("hs_reject", {31'h0, acc}, 32'h0);
    step(1'b1, 8'h09, 8'h01, 1'b1, 32'h0000_002D, 1'b0, acc);
    check("clr_after_hs", {29'h0, acc, mac_clr, in_ready}, 32'h2);
    step(1'b1, 8'h09, 8'h01, 1'b1, 32'h0000_002D, 1'b0, acc);
    check("first_pop_ready", {29'h0, acc, in_ready, mac_valid}, 32'h3);
    check("first_pop_pair", {16'h0, mac_a, mac_b}, 32'h0000_0101);
    push_until(8'h09, 8'h01, 1'b1, 32'h0000_002D, 1'b0);
    auto_ready = 1'b1;
    wait_results(200);

    // Reset during DRAIN discards the partial result and the buffered product
    push_until(8'h05, 8'h05, 1'b1, 32'h0000_0019, 1'b0);
    push_until(8'h06, 8'h06, 1'b1, 32'h0000_0024, 1'b0);
    for (int unsigned i = 0; i < 20 && !(mac_valid && mac_a == 8'h05); i++) idle(1);
    check("drain_pair_seen", {16'h0, mac_a, mac_b}, 32'h0000_0505);
    reset = 1'b1;
    exp_res_q.delete();
    exp_pair_q.delete();
    idle(1);
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("mid_rst_mac", {13'h0, mac_a, mac_b, mac_valid, mac_clr, mac_out_HL}, 32'h0);
    check("mid_rst_res_flags", {30'h0, res_valid, res_error}, 32'h0);
    check("mid_rst_res_data", res_data, 32'h0);
    check("mid_rst_stat", {16'h0, stat_pairs}, 32'h0);
    reset = 1'b0;
    quiet = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      idle(1);
      if (mac_clr || mac_valid || res_valid) quiet++;
    end
    check("post_rst_quiet", quiet, 32'd0);
    check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

    check("pairs_left", exp_pair_q.size(), 32'h0);
    check("results_left", exp_res_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
